switch_sched: RTL
=================

# switch_sched

Four-port crossbar scheduler for the packet switch: accepts one-word transfers from up to four devices, each tagged with a 2-bit destination port, and delivers each word to its destination device's receive side. Each output port has its own arbiter and FSM; contention for one output resolves round-robin. The scheduler latches the word at grant time, so a source may change address/data after handshake completion without corrupting the delivered word. Sits between the device transmit interfaces (valid/ack) and the device receive interfaces (valid/ack).

## Interface
- DW, 4, data width per port
- Port count fixed at 4 (2-bit address); port i uses in_adr_i[2i+1:2i], in_dat_i[DW*i +: DW], out_dat_o[DW*j +: DW]

- clk_i  in  1  clock; all state on rising edge
- rst_ni  in  1  asynchronous active-low reset
- in_valid_i  in  4  source i requests a transfer (device validtx)
- in_adr_i  in  8  destination port of source i
- in_dat_i  in  4*DW  data word of source i
- in_ack_o  out  4  transfer from source i complete (device acktx)
- out_valid_o  out  4  word available on output j (device validrx)
- out_dat_o  out  4*DW  latched word for output j
- out_ack_i  in  4  output j accepted the word (device ackrx)
- out_busy_o  out  4  output j not IDLE

## Operation
- Per-output FSM, states IDLE, SEND, DONE; per-output registers src[1:0], dat[DW-1:0], ptr[1:0].
- Request vector for output j: req[i] = in_valid_i[i] & (in_adr_i[i] == j) & ~lock[i]; lock[i] = source i is src of some output in SEND or DONE.
- IDLE: if req nonzero, pick winner by arbitration, src<=winner, dat<=in_dat_i[winner], out_valid_o[j]<=1, -> SEND.
- Same-cycle requests to different outputs grant independently; a source cannot win two outputs (single address per cycle).
- SEND: out_valid_o[j] held 1, out_dat_o[j] held at dat. On out_ack_i[j]=1: out_valid_o[j]<=0, in_ack_o[src]<=1, -> DONE.
- DONE: in_ack_o[src] held 1. When in_valid_i[src]=0 and out_ack_i[j]=0 sampled together: in_ack_o[src]<=0, ptr<=src+1 (mod 4), -> IDLE.
- in_ack_o[i] is the OR over outputs; at most one output holds source i.
- Source address/data changes during SEND/DONE are ignored (word already latched, source locked).
- out_dat_o[j] keeps last delivered word in IDLE.
- Reset (any time, incl. mid-transfer): all FSMs IDLE, ptr=0, src=0, dat=0; in_ack_o, out_valid_o, out_busy_o, out_dat_o = 0 immediately, no transfer resumes after release.

## Timing
- Grant latency: in_valid_i sampled high at edge k (IDLE, source wins) -> out_valid_o high after edge k.
- Ack forwarding: out_ack_i sampled high at edge m -> in_ack_o high and out_valid_o low after edge m.
- Release: in_ack_o falls after first edge sampling in_valid_i[src]=0 and out_ack_i[j]=0; next grant on output j possible at following edge.
- Minimum transfer with devices that respond in one cycle: 4 clocks per word per output.
- out_valid_o never rises while out_ack_i[j] is high (protected by DONE wait).

## Configuration
- SWITCH_SCHED_RR_EN defined: round-robin; search starts at ptr[j], first requesting index wins, ptr updated on DONE exit.
- Undefined: fixed priority, lowest index wins; ptr held 0 and unused.

## Test plan
- Single transfer: source 1 sends dat=0xA to port 2, device acks one cycle later -> out_valid_o[2] one cycle after request, out_dat_o[2]=0xA, in_ack_o[1] pulses until validtx drops, other outputs idle.
- Contention: sources 0,1,3 all target port 0 continuously (RR_EN) -> grant order 0,1,3,0; without RR_EN -> 0 every time while source 0 keeps requesting.
- Parallel: source 0->port 3 and source 2->port 1 same cycle -> both out_valid_o rise same edge, independent completion.
- Data churn: source 0 changes in_dat_i/in_adr_i every cycle after grant -> delivered word equals value at grant edge; no second grant to another port until its in_ack_o falls.
- Slow receiver: out_ack_i[1] delayed 5 cycles -> out_valid_o[1] held 5 cycles, in_ack_o low throughout, out_busy_o[1]=1.
- Reset mid-SEND: rst_ni low while out_valid_o[2]=1 -> all outputs 0 immediately; after release, no out_valid_o until a fresh request.

Source files
------------

// File: rtl/switch_sched.sv
// Four-port crossbar scheduler. Each output has its own arbiter and IDLE/SEND/DONE FSM.
// Latency: a request sampled at edge k shows out_valid_o after edge k. out_ack_i shows in_ack_o one edge later.
// Backpressure: a word is held on out_valid_o/out_dat_o until out_ack_i. in_ack_o is held until the source drops in_valid_i.
//
// Ports (port i uses in_adr_i[2i+1:2i] and in_dat_i[DW*i +: DW]; output j uses out_dat_o[DW*j +: DW]):
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   in_valid_i/in_adr_i/in_dat_i/in_ack_o   source side (device validtx / acktx)
//   out_valid_o/out_dat_o/out_ack_i         destination side (device validrx / ackrx)
//   out_busy_o              output j FSM is not IDLE
//
// Build option: SWITCH_SCHED_RR_EN
//   defined   - round-robin arbitration per output. The search starts at ptr.
//   undefined - fixed priority, where the lowest index wins.
module switch_sched #(
    parameter int DW = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [3:0]    in_valid_i,
    input  logic [7:0]    in_adr_i,
    input  logic [4*DW-1:0] in_dat_i,
    output logic [3:0]    in_ack_o,
    output logic [3:0]    out_valid_o,
    output logic [4*DW-1:0] out_dat_o,
    input  logic [3:0]    out_ack_i,
    output logic [3:0]    out_busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Per-output registered state, flattened so that the cross-output logic can see it.
    logic [3:0] busy;
    logic [7:0] src_flat;
    logic [3:0] ack_flat;

    // A source stays locked while it owns any output in SEND or DONE.
    // The lock keeps an address change during a transfer from winning a second output.
    logic [3:0] lock;

    always_comb begin
        lock = '0;
        for (int j = 0; j < 4; j++) begin
            if (busy[j]) begin
                lock[src_flat[2*j +: 2]] = 1'b1;
            end
        end
    end

    // The search starts at index start and wraps modulo 4. The first requester found wins.
    // The result is {found, index}.
    function automatic logic [2:0] arb_pick(input logic [3:0] req, input logic [1:0] start);
        logic [1:0] idx;
        arb_pick = 3'b000;
        // The loop walks downwards so that the nearest index to start is the last one written.
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (req[idx]) begin
                arb_pick = {1'b1, idx};
            end
        end
    endfunction

    for (genvar j = 0; j < 4; j++) begin : g_out
        state_t        state_q;
        logic [1:0]    src_q;
        logic [DW-1:0] dat_q;
        logic          vld_q;
        logic          ack_q;
        logic [3:0]    req;
        logic [1:0]    start;
        logic [2:0]    pick;

        always_comb begin
            req = '0;
            for (int i = 0; i < 4; i++) begin
                req[i] = in_valid_i[i] & (in_adr_i[2*i +: 2] == 2'(j)) & ~lock[i];
            end
        end

`ifdef SWITCH_SCHED_RR_EN
        logic [1:0] ptr_q;
        assign start = ptr_q;
`else
        assign start = 2'd0;
`endif

        assign pick = arb_pick(req, start);

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= ST_IDLE;
                src_q   <= 2'd0;
                dat_q   <= '0;
                vld_q   <= 1'b0;
                ack_q   <= 1'b0;
`ifdef SWITCH_SCHED_RR_EN
                ptr_q   <= 2'd0;
`endif
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (pick[2]) begin
                            // The word is captured here. Later changes on the source are ignored.
                            src_q   <= pick[1:0];
                            dat_q   <= in_dat_i[DW*pick[1:0] +: DW];
                            vld_q   <= 1'b1;
                            state_q <= ST_SEND;
                        end
                    end
                    ST_SEND: begin
                        if (out_ack_i[j]) begin
                            vld_q   <= 1'b0;
                            ack_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        // Waiting for the receiver to drop its ack here keeps out_valid_o
                        // from rising while out_ack_i is still high.
                        if (!in_valid_i[src_q] && !out_ack_i[j]) begin
                            ack_q   <= 1'b0;
`ifdef SWITCH_SCHED_RR_EN
                            ptr_q   <= src_q + 2'd1;
`endif
                            state_q <= ST_IDLE;
                        end
                    end
                    default: begin
                        vld_q   <= 1'b0;
                        ack_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end

        assign busy[j]               = (state_q != ST_IDLE);
        assign src_flat[2*j +: 2]    = src_q;
        assign ack_flat[j]           = ack_q;
        assign out_valid_o[j]        = vld_q;
        assign out_dat_o[DW*j +: DW] = dat_q;
        assign out_busy_o[j]         = busy[j];
    end

    // At most one output holds a given source, so this OR never merges two owners.
    always_comb begin
        in_ack_o = '0;
        for (int j = 0; j < 4; j++) begin
            if (ack_flat[j]) begin
                in_ack_o[src_flat[2*j +: 2]] = 1'b1;
            end
        end
    end

endmodule
